// File: rtl/mem_arb_pkg.sv
// Shared constants for the instruction/data memory arbiter:
// FSM state encoding, wait-counter width and the default abort timeout.
package mem_arb_pkg;

    // Default number of un-acknowledged busy cycles before an access is aborted.
    localparam int TIMEOUT_DEFAULT = 255;

    // Width of the busy-cycle wait counter.
    localparam int CNT_W = 8;

    // Arbiter FSM state encoding.
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_IF_BUSY = 2'd1;
    localparam logic [1:0] ST_DM_BUSY = 2'd2;

endpackage

// File: rtl/wait_timer.sv
// Busy-cycle wait counter for the memory arbiter.
// Counts cycles spent waiting for a memory acknowledge and flags the cycle in
// which the TIMEOUT-th un-acknowledged cycle is reached.
module wait_timer
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count_reg;

    // Counter: cleared by reset or clear, otherwise advances once per enabled cycle.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    // Expiry is flagged during the last permitted waiting cycle, so the
    // owner can abort in that same cycle when no acknowledge arrives.
    assign expire = (count_reg == LAST_COUNT);

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between the fetch stage and the
// memory stage. Data requests normally win, but a fetch that was passed over
// once is granted at the next opportunity. Every access is followed by one
// idle cycle; an access not acknowledged within TIMEOUT cycles is aborted
// with zero read data and a sticky error flag.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    // fetch port
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_rdata,
    // data port
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_ready,
    output logic [31:0] dm_rdata,
    // shared memory
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    // pipeline control / status
    output logic        stall_if,
    output logic        stall_dm,
    output logic        err
);

    logic [1:0]  state_reg;
    logic [1:0]  state_next;
    logic [31:0] addr_reg;
    logic        we_reg;
    logic [31:0] wdata_reg;
    logic        err_reg;
    logic        fetch_owed_reg;

    logic idle;
    logic if_busy;
    logic dm_busy;
    logic busy;
    logic grant_dm;
    logic grant_if;
    logic expire;
    logic abort;
    logic finish;

    assign idle    = (state_reg == ST_IDLE);
    assign if_busy = (state_reg == ST_IF_BUSY);
    assign dm_busy = (state_reg == ST_DM_BUSY);
    assign busy    = if_busy | dm_busy;

    // Data has priority unless a fetch was already passed over by the previous grant.
    assign grant_dm = idle & dm_req & ~(if_req & fetch_owed_reg);
    assign grant_if = idle & if_req & ~grant_dm;

    // Timeout is only meaningful while busy; a same-cycle acknowledge wins.
    // Completion is masked while reset is asserted so a reset never yields a ready pulse.
    assign abort  = busy & ~mem_ack & expire & rst_n;
    assign finish = busy & rst_n & (mem_ack | expire);

    wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (~busy),
        .enable (busy & ~mem_ack),
        .expire (expire)
    );

    // Next-state selection for the grant / wait / release sequence.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (grant_dm) begin
                    state_next = ST_DM_BUSY;
                end else if (grant_if) begin
                    state_next = ST_IF_BUSY;
                end
            end
            ST_IF_BUSY, ST_DM_BUSY: begin
                if (mem_ack || expire) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State, latched request fields, fairness flag and sticky error.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            addr_reg       <= '0;
            we_reg         <= 1'b0;
            wdata_reg      <= '0;
            err_reg        <= 1'b0;
            fetch_owed_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (grant_dm) begin
                addr_reg       <= dm_addr;
                we_reg         <= dm_we;
                wdata_reg      <= dm_wdata;
                fetch_owed_reg <= if_req;
            end else if (grant_if) begin
                addr_reg       <= if_addr;
                we_reg         <= 1'b0;
                wdata_reg      <= '0;
                fetch_owed_reg <= 1'b0;
            end
            if (abort) begin
                err_reg <= 1'b1;
            end
        end
    end

    // Memory side is driven purely from the latched request.
    assign mem_en    = busy;
    assign mem_we    = dm_busy & we_reg;
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;

    // Requester responses: ready on acknowledge or abort, zero data on abort.
    assign if_ready = if_busy & finish;
    assign dm_ready = dm_busy & finish;
    assign if_rdata = (if_busy && mem_ack) ? mem_rdata : 32'h0;
    assign dm_rdata = (dm_busy && mem_ack) ? mem_rdata : 32'h0;

    assign stall_if = if_req & ~if_ready;
    assign stall_dm = dm_req & ~dm_ready;
    assign err      = err_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random
// traffic, all checked every cycle against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int TO = 4;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ready;
    logic [31:0] dm_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        stall_if;
    logic        stall_dm;
    logic        err;

    int n_vec  = 0;
    int n_fail = 0;

    mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ready  (if_ready),
        .if_rdata  (if_rdata),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_ready  (dm_ready),
        .dm_rdata  (dm_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .stall_if  (stall_if),
        .stall_dm  (stall_dm),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the access currently owning memory, if any.
    bit          m_busy;
    bit          m_dm;
    logic [31:0] m_addr;
    bit          m_we;
    logic [31:0] m_wdata;
    int          m_wait;
    bit          m_err;
    bit          m_owed;   // a fetch was passed over by the last data grant

    // Expected combinational outputs for the current cycle.
    bit          e_en, e_we, e_if_ready, e_dm_ready;
    logic [31:0] e_rdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Let inputs settle, derive expectations from the model and compare.
    task automatic settle();
        bit done;
        #1;
        e_en       = m_busy;
        e_we       = m_busy && m_dm && m_we;
        done       = m_busy && rst_n && (mem_ack || (m_wait == TO - 1));
        e_if_ready = done && !m_dm;
        e_dm_ready = done && m_dm;
        e_rdata    = mem_ack ? mem_rdata : 32'h0;
        check("mem_en", {31'b0, mem_en}, {31'b0, e_en});
        check("mem_we", {31'b0, mem_we}, {31'b0, e_we});
        if (e_en) check("mem_addr", mem_addr, m_addr);
        if (e_we) check("mem_wdata", mem_wdata, m_wdata);
        check("if_ready", {31'b0, if_ready}, {31'b0, e_if_ready});
        check("dm_ready", {31'b0, dm_ready}, {31'b0, e_dm_ready});
        if (e_if_ready) check("if_rdata", if_rdata, e_rdata);
        if (e_dm_ready) check("dm_rdata", dm_rdata, e_rdata);
        check("stall_if", {31'b0, stall_if}, {31'b0, if_req && !e_if_ready});
        check("stall_dm", {31'b0, stall_dm}, {31'b0, dm_req && !e_dm_ready});
        check("err", {31'b0, err}, {31'b0, m_err});
    endtask

    // Advance one clock and update the model from the sampled inputs.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            m_busy = 0; m_dm = 0; m_addr = '0; m_we = 0; m_wdata = '0;
            m_wait = 0; m_err = 0; m_owed = 0;
        end else if (m_busy) begin
            if (mem_ack) begin
                m_busy = 0;
            end else if (m_wait == TO - 1) begin
                m_busy = 0;
                m_err  = 1;
            end else begin
                m_wait++;
            end
        end else if (if_req && (!dm_req || m_owed)) begin
            m_busy = 1; m_dm = 0; m_addr = if_addr; m_we = 0; m_wdata = '0;
            m_wait = 0; m_owed = 0;
        end else if (dm_req) begin
            m_busy = 1; m_dm = 1; m_addr = dm_addr; m_we = dm_we; m_wdata = dm_wdata;
            m_wait = 0; m_owed = if_req;
        end
        @(negedge clk);
    endtask

    task automatic cyc();
        settle();
        tick();
    endtask

    initial begin
        rst_n = 0; if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0;
        dm_addr = '0; dm_wdata = '0; mem_rdata = '0; mem_ack = 0;
        m_busy = 0; m_dm = 0; m_addr = '0; m_we = 0; m_wdata = '0;
        m_wait = 0; m_err = 0; m_owed = 0;
        @(negedge clk);

        // Reset state
        cyc();
        settle();
        tick();
        rst_n = 1;
        settle();
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_err", {31'b0, err}, 32'h0);
        tick();

        // Fetch only: two busy cycles, ack in the second
        if_req = 1; if_addr = 32'h0040_0000;
        settle(); check("f_idle_stall", {31'b0, stall_if}, 32'h1); tick();
        settle(); check("f_en1", {31'b0, mem_en}, 32'h1); check("f_stall1", {31'b0, stall_if}, 32'h1); tick();
        mem_ack = 1; mem_rdata = 32'h2008_0005;
        settle();
        check("f_addr", mem_addr, 32'h0040_0000);
        check("f_ready", {31'b0, if_ready}, 32'h1);
        check("f_rdata", if_rdata, 32'h2008_0005);
        tick();
        if_req = 0; mem_ack = 0;
        settle(); check("f_release", {31'b0, mem_en}, 32'h0); tick();

        // Simultaneous requests: data first, then the waiting fetch, even with data still asking
        if_req = 1; if_addr = 32'h0040_0004;
        dm_req = 1; dm_we = 0; dm_addr = 32'h1001_0004;
        cyc();
        mem_ack = 1; mem_rdata = 32'h1111_2222;
        settle();
        check("s_dm_addr", mem_addr, 32'h1001_0004);
        check("s_dm_ready", {31'b0, dm_ready}, 32'h1);
        check("s_dm_rdata", dm_rdata, 32'h1111_2222);
        tick();
        mem_ack = 0; dm_addr = 32'h1001_0010;
        settle(); check("s_gap", {31'b0, mem_en}, 32'h0); tick();
        mem_ack = 1; mem_rdata = 32'h3333_4444;
        settle();
        check("s_if_addr", mem_addr, 32'h0040_0004);
        check("s_if_ready", {31'b0, if_ready}, 32'h1);
        tick();
        if_req = 0; mem_ack = 0;
        cyc();
        mem_ack = 1;
        settle(); check("s_dm2_addr", mem_addr, 32'h1001_0010); tick();
        dm_req = 0; mem_ack = 0;
        cyc();

        // Store with address changed mid-access
        dm_req = 1; dm_we = 1; dm_wdata = 32'hDEAD_BEEF; dm_addr = 32'h1001_0008;
        cyc();
        settle();
        check("st_we", {31'b0, mem_we}, 32'h1);
        check("st_wdata", mem_wdata, 32'hDEAD_BEEF);
        tick();
        dm_addr = 32'h1234_5678;
        settle(); check("st_addr_hold", mem_addr, 32'h1001_0008); tick();
        mem_ack = 1;
        settle(); check("st_ready", {31'b0, dm_ready}, 32'h1); tick();
        dm_req = 0; dm_we = 0; mem_ack = 0;
        cyc();

        // Timeout abort, sticky error
        dm_req = 1; dm_addr = 32'h1001_0020; mem_rdata = 32'hFFFF_FFFF;
        cyc();
        for (int i = 0; i < TO - 1; i++) begin
            settle(); check("to_wait", {31'b0, dm_ready}, 32'h0); tick();
        end
        settle();
        check("to_ready", {31'b0, dm_ready}, 32'h1);
        check("to_rdata", dm_rdata, 32'h0);
        tick();
        dm_req = 0;
        settle(); check("to_err", {31'b0, err}, 32'h1); tick();
        if_req = 1; if_addr = 32'h0040_0100;
        cyc();
        mem_ack = 1; mem_rdata = 32'h0BAD_F00D;
        settle(); check("to_next_rdata", if_rdata, 32'h0BAD_F00D); tick();
        if_req = 0; mem_ack = 0;
        settle(); check("to_err_sticky", {31'b0, err}, 32'h1); tick();

        // Reset during a fetch
        if_req = 1; if_addr = 32'h0040_0200;
        cyc();
        rst_n = 0;
        settle(); check("rb_ready", {31'b0, if_ready}, 32'h0); tick();
        rst_n = 1; if_req = 0;
        settle();
        check("rb_en", {31'b0, mem_en}, 32'h0);
        check("rb_err", {31'b0, err}, 32'h0);
        tick();

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            rst_n     = ($urandom_range(0, 199) != 0);
            mem_ack   = ($urandom_range(0, 2) == 0);
            mem_rdata = $urandom;
            if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1; if_addr = $urandom;
            end
            if (!dm_req && $urandom_range(0, 2) == 0) begin
                dm_req = 1; dm_we = $urandom_range(0, 1); dm_addr = $urandom; dm_wdata = $urandom;
            end
            cyc();
            if (e_if_ready) if_req = 0;
            if (e_dm_ready) dm_req = 0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum cycles a granted access waits for mem_ack before abort; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 if_req  input  1  fetch stage requests an instruction read.
REQ-005 if_addr  input  32  fetch address.
REQ-006 if_ready  output  1  fetch access complete this cycle.
REQ-007 if_rdata  output  32  instruction word, valid while if_ready=1.
REQ-008 dm_req  input  1  memory stage requests a load or store.
REQ-009 dm_we  input  1  1=store, 0=load.
REQ-010 dm_addr  input  32  data address.
REQ-011 dm_wdata  input  32  store data.
REQ-012 dm_ready  output  1  data access complete this cycle.
REQ-013 dm_rdata  output  32  load data, valid while dm_ready=1.
REQ-014 mem_en  output  1  access active on the shared single-port memory.
REQ-015 mem_we  output  1  write strobe to memory.
REQ-016 mem_addr  output  32  memory address.
REQ-017 mem_wdata  output  32  memory write data.
REQ-018 mem_rdata  input  32  memory read data, valid with mem_ack.
REQ-019 mem_ack  input  1  memory completes current access this cycle.
REQ-020 stall_if  output  1  if_req & ~if_ready; drives fetch/decode stall to hazard logic.
REQ-021 stall_dm  output  1  dm_req & ~dm_ready; freezes whole pipeline.
REQ-022 err  output  1  sticky timeout flag.

Function
REQ-023 FSM states: IDLE, IF_BUSY, DM_BUSY; exactly one state active.
REQ-024 IDLE: dm_req=1 -> DM_BUSY; else if_req=1 -> IF_BUSY; else stay; simultaneous requests: data wins.
REQ-025 On IDLE exit, requester's addr, we (0 for fetch), wdata latched into registers; mem_addr/mem_we/mem_wdata driven only from these registers.
REQ-026 mem_en=1 exactly while state is IF_BUSY or DM_BUSY; mem_we=latched we in DM_BUSY, 0 otherwise; mem_* stable throughout busy state.
REQ-027 if_ready=(IF_BUSY & mem_ack) | fetch abort; dm_ready likewise for DM_BUSY; both combinational, single-cycle pulses.
REQ-028 if_rdata/dm_rdata=mem_rdata when matching ready from ack; 32'h0 on abort; don't-care otherwise.
REQ-029 Busy state with mem_ack=1 -> IDLE next cycle; mandatory IDLE cycle between accesses, so minimum 2 cycles per access, first access granted 1 cycle after request.
REQ-030 Latency: req at cycle N in IDLE -> mem_en at N+1 -> ready in the cycle mem_ack arrives (earliest N+1).
REQ-031 mem_ack in IDLE is ignored; no ready generated.
REQ-032 Requester holds req/addr until ready; deassertion while busy does not cancel the access (access completes, ready still pulses).
REQ-033 8-bit wait counter cleared on entering busy state, increments each busy cycle without ack; after TIMEOUT such cycles (counter==TIMEOUT-1, no ack): abort -> ready pulse with rdata=0, err<=1, -> IDLE.
REQ-034 mem_ack in the abort cycle takes precedence: normal completion, no error.
REQ-035 err remains 1 until reset.
REQ-036 Starvation bound: a pending fetch granted after at most one data access.

Reset
REQ-037 rst_n=0 at a clock edge: state=IDLE, counter=0, latched addr/we/wdata=0, err=0; hence mem_en=0, mem_we=0, ready outputs 0.
REQ-038 Reset mid-access aborts silently: no ready pulse, no err; mem_en low the cycle after the reset edge.

Structure
REQ-039 Package mem_arb_pkg holds FSM state encoding constants and TIMEOUT default.
REQ-040 One sub-module, wait_timer: 8-bit counter with clear, enable, expire output against TIMEOUT.
REQ-041 Target size 120-400 lines RTL, no memories inferred.

Verification
REQ-042 Fetch only: if_req=1, if_addr=0x0040_0000, mem_ack 2 cycles after mem_en, mem_rdata=0x2008_0005 -> mem_en 2 cycles, if_ready 1 cycle with if_rdata=0x2008_0005, stall_if high until then.
REQ-043 Simultaneous if_req and dm_req load at 0x1001_0004 -> DM_BUSY first, dm_ready, one IDLE cycle, then IF_BUSY; fetch never starved.
REQ-044 Store dm_we=1, dm_wdata=0xDEAD_BEEF, addr 0x1001_0008 -> mem_we=1, mem_wdata=0xDEAD_BEEF stable until ack; dm_addr changed mid-access does not alter mem_addr.
REQ-045 TIMEOUT=4, no mem_ack -> abort after 4 busy cycles, dm_ready with dm_rdata=0, err=1 sticky; next access ack'd normally, err stays 1.
REQ-046 rst_n=0 during IF_BUSY -> next cycle mem_en=0, no if_ready, err=0, state IDLE.
